// File: rtl/m68k_bus_pkg.sv
// Shared types, sizes and strobe idle levels for the 68000 bus-cycle sequencer.
package m68k_bus_pkg;

  localparam int unsigned ADDR_W           = 23;
  localparam int unsigned DATA_W           = 16;
  localparam int unsigned BE_W             = 2;
  localparam int unsigned WAIT_TIMEOUT_DEF = 255;
  localparam int unsigned TMO_W_DEF        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ASSERT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LATCH  = 3'd4,
    ST_TERM   = 3'd5
  } bus_state_e;

  // Request attributes that steer strobes for the whole cycle
  typedef struct packed {
    logic            rw;
    logic [BE_W-1:0] be;
  } bus_ctl_t;

  typedef struct packed {
    logic as_n;
    logic uds_n;
    logic lds_n;
    logic doe;
  } strobe_t;

  localparam strobe_t STROBES_IDLE = '{as_n: 1'b1, uds_n: 1'b1, lds_n: 1'b1, doe: 1'b0};

  // Strobe levels for a given state; writes hold DS off until WAIT so data settles first
  function automatic strobe_t strobes_for(bus_state_e st, logic rw, logic [BE_W-1:0] be);
    strobe_t s;
    s = STROBES_IDLE;
    case (st)
      ST_ASSERT: begin
        s.as_n = 1'b0;
        s.doe  = ~rw;
        if (rw) {s.uds_n, s.lds_n} = ~be;
      end
      ST_WAIT, ST_LATCH: begin
        s.as_n             = 1'b0;
        s.doe              = ~rw;
        {s.uds_n, s.lds_n} = ~be;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/m68k_bus_fsm_if.sv
// Request/response handshake plus 68000 bus pins between the sequencer and its environment.
interface m68k_bus_fsm_if;
  import m68k_bus_pkg::*;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_RW;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [BE_W-1:0]   REQ_BE;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              RESP_VALID;
  logic              RESP_ERR;
  logic [DATA_W-1:0] RESP_RDATA;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic              BUS_RW;
  logic              BUS_AS_N;
  logic              BUS_UDS_N;
  logic              BUS_LDS_N;
  logic [DATA_W-1:0] BUS_DOUT;
  logic              BUS_DOE;
  logic [DATA_W-1:0] BUS_DIN;

  modport master (
    input  REQ_VALID, REQ_RW, REQ_ADDR, REQ_BE, REQ_WDATA, BUS_DIN,
    output REQ_READY, RESP_VALID, RESP_ERR, RESP_RDATA,
           BUS_ADDR, BUS_RW, BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_DOUT, BUS_DOE
  );

  modport slave (
    output REQ_VALID, REQ_RW, REQ_ADDR, REQ_BE, REQ_WDATA, BUS_DIN,
    input  REQ_READY, RESP_VALID, RESP_ERR, RESP_RDATA,
           BUS_ADDR, BUS_RW, BUS_AS_N, BUS_UDS_N, BUS_LDS_N, BUS_DOUT, BUS_DOE
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Saturating count of MCCLK falling edges spent waiting for DTACK.
module bus_wait_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_next;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Asserted when the pending increment would reach the limit
  assign cnt_next = {1'b0, cnt_q} + (W+1)'(1);
  assign expire_c = (cnt_next >= (W+1)'(LIMIT));

  always_ff @(negedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/m68k_bus_fsm.sv
// 68000 bus-cycle sequencer: turns one request into an AS/DS/DTACK cycle paced by MCCLK falling edges.
module m68k_bus_fsm
  import m68k_bus_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
  parameter int unsigned TMO_W        = TMO_W_DEF
) (
  input  logic                  SYSCLK,
  input  logic                  RESET,
  input  logic                  MCCLK_FALLING,
  input  logic                  DTACK_LATCH,
  m68k_bus_fsm_if.master        bus
);

  bus_state_e        state_q, state_d;
  bus_ctl_t          ctl_q, ctl_d;
  strobe_t           strobe_q, strobe_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_dout_q, bus_dout_d;
  logic              bus_rw_q, bus_rw_d;
  logic              dtack_seen_q, dtack_seen_d;
  logic              err_q, err_d;
  logic              tmr_clr, tmr_inc, tmr_expire_c;

  bus_wait_timer #(.LIMIT(WAIT_TIMEOUT), .W(TMO_W)) u_wait_timer (
    .clk      (SYSCLK),
    .rst      (RESET),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .expire_c (tmr_expire_c)
  );

  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    rdata_d      = rdata_q;
    bus_addr_d   = bus_addr_q;
    bus_dout_d   = bus_dout_q;
    bus_rw_d     = bus_rw_q;
    dtack_seen_d = dtack_seen_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID && req_ready_q) begin
          ctl_d        = '{rw: bus.REQ_RW, be: bus.REQ_BE};
          bus_addr_d   = bus.REQ_ADDR;
          bus_rw_d     = bus.REQ_RW;
          bus_dout_d   = bus.REQ_WDATA;
          dtack_seen_d = 1'b0;
          err_d        = 1'b0;
          tmr_clr      = 1'b1;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (MCCLK_FALLING) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (DTACK_LATCH)   dtack_seen_d = 1'b1;
        if (MCCLK_FALLING) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (DTACK_LATCH) dtack_seen_d = 1'b1;
        // A DTACK strobe landing on the same edge still ends the wait
        if (MCCLK_FALLING) begin
          if (dtack_seen_q || DTACK_LATCH) begin
            state_d = ST_LATCH;
          end else begin
            tmr_inc = 1'b1;
            if (tmr_expire_c) begin
              err_d   = 1'b1;
              state_d = ST_TERM;
            end
          end
        end
      end
      ST_LATCH: begin
        if (MCCLK_FALLING) begin
          if (ctl_q.rw) rdata_d = bus.BUS_DIN;
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        if (MCCLK_FALLING) begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          bus_rw_d     = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs follow the state being entered
    strobe_d    = strobes_for(state_d, ctl_d.rw, ctl_d.be);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(negedge SYSCLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      ctl_q        <= '{rw: 1'b1, be: '0};
      strobe_q     <= STROBES_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      bus_addr_q   <= '0;
      bus_dout_q   <= '0;
      bus_rw_q     <= 1'b1;
      dtack_seen_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      strobe_q     <= strobe_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_dout_q   <= bus_dout_d;
      bus_rw_q     <= bus_rw_d;
      dtack_seen_q <= dtack_seen_d;
      err_q        <= err_d;
    end
  end

  assign bus.REQ_READY  = req_ready_q;
  assign bus.RESP_VALID = resp_valid_q;
  assign bus.RESP_ERR   = resp_err_q;
  assign bus.RESP_RDATA = rdata_q;
  assign bus.BUS_ADDR   = bus_addr_q;
  assign bus.BUS_RW     = bus_rw_q;
  assign bus.BUS_AS_N   = strobe_q.as_n;
  assign bus.BUS_UDS_N  = strobe_q.uds_n;
  assign bus.BUS_LDS_N  = strobe_q.lds_n;
  assign bus.BUS_DOE    = strobe_q.doe;
  assign bus.BUS_DOUT   = bus_dout_q;

endmodule

// File: tb/tb_m68k_bus_fsm.sv
// Directed vector bench for m68k_bus_fsm with a short wait timeout.
module tb_m68k_bus_fsm;
  import m68k_bus_pkg::*;

  typedef struct packed {
    logic        rst, mcf, dtk, vld, rw;
    logic [22:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata, din;
  } vin_t;

  typedef struct packed {
    logic        rdy, rv, re;
    logic [15:0] rdata;
    logic        as_n, uds_n, lds_n, doe, rw;
    logic [22:0] addr;
    logic [15:0] dout;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst, mcf, dtk;
  int   errors = 0;
  int   checks = 0;
  vec_t tv[$];

  m68k_bus_fsm_if bif ();

  m68k_bus_fsm #(.WAIT_TIMEOUT(4), .TMO_W(8)) dut (
    .SYSCLK        (clk),
    .RESET         (rst),
    .MCCLK_FALLING (mcf),
    .DTACK_LATCH   (dtk),
    .bus           (bif)
  );

  always #5 clk = ~clk;

  // DUT acts on negedge; observe on the following posedge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic add(input logic r, m, d, v, w, input logic [22:0] a, input logic [1:0] be,
                     input logic [15:0] wd, di, input logic rdy, rv, re, input logic [15:0] rd,
                     input logic as_n, uds, lds, doe, orw, input logic [22:0] oa, input logic [15:0] od);
    vec_t t;
    t.i = '{rst: r, mcf: m, dtk: d, vld: v, rw: w, addr: a, be: be, wdata: wd, din: di};
    t.o = '{rdy: rdy, rv: rv, re: re, rdata: rd, as_n: as_n, uds_n: uds, lds_n: lds,
            doe: doe, rw: orw, addr: oa, dout: od};
    tv.push_back(t);
  endtask

  function automatic vout_t observe();
    vout_t o;
    o = '{rdy: bif.REQ_READY, rv: bif.RESP_VALID, re: bif.RESP_ERR, rdata: bif.RESP_RDATA,
          as_n: bif.BUS_AS_N, uds_n: bif.BUS_UDS_N, lds_n: bif.BUS_LDS_N, doe: bif.BUS_DOE,
          rw: bif.BUS_RW, addr: bif.BUS_ADDR, dout: bif.BUS_DOUT};
    return o;
  endfunction

  task automatic drive(input vin_t i);
    rst           = i.rst;
    mcf           = i.mcf;
    dtk           = i.dtk;
    bif.REQ_VALID = i.vld;
    bif.REQ_RW    = i.rw;
    bif.REQ_ADDR  = i.addr;
    bif.REQ_BE    = i.be;
    bif.REQ_WDATA = i.wdata;
    bif.BUS_DIN   = i.din;
  endtask

  task automatic apply_range(input int lo, input int hi);
    vout_t got;
    for (int k = lo; k <= hi; k++) begin
      drive(tv[k].i);
      tick();
      got = observe();
      checks++;
      if (got !== tv[k].o) begin
        errors++;
        $display("FAIL vec%0d: got rdy/rv/re/rdata/as/uds/lds/doe/rw/addr/dout=%h want %h", k, got, tv[k].o);
      end
    end
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; mcf = 1'b0; dtk = 1'b0;
    bif.REQ_VALID = 1'b0; bif.REQ_RW = 1'b1; bif.REQ_ADDR = '0;
    bif.REQ_BE = '0; bif.REQ_WDATA = '0; bif.BUS_DIN = '0;

    //   rst mcf dtk vld rw addr        be     wdata     din      | rdy rv re rdata    as uds lds doe rw addr        dout
    // Reset, then read of 0x000400 with DTACK in the second WAIT cycle
    add(1, 0, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    1, 0, 0, 16'h0,    1, 1, 1, 0, 1, 23'h0,      16'h0);
    add(0, 0, 0, 1, 1, 23'h000400, 2'b11, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 1, 1, 0, 1, 23'h000400, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 1, 23'h000400, 16'h0);
    add(0, 0, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 1, 23'h000400, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 1, 23'h000400, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 1, 23'h000400, 16'h0);
    add(0, 0, 1, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 1, 23'h000400, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 1, 23'h000400, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'hBEEF, 0, 0, 0, 16'hBEEF, 1, 1, 1, 0, 1, 23'h000400, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    1, 1, 0, 16'hBEEF, 1, 1, 1, 0, 1, 23'h000400, 16'h0);
    add(0, 0, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    1, 0, 0, 16'hBEEF, 1, 1, 1, 0, 1, 23'h000400, 16'h0);
    // Upper-byte write: DOE from ASSERT, UDS only from WAIT, LDS never
    add(0, 0, 0, 1, 0, 23'h012345, 2'b10, 16'h1234, 16'h0,    0, 0, 0, 16'hBEEF, 1, 1, 1, 0, 0, 23'h012345, 16'h1234);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 1, 1, 1, 0, 23'h012345, 16'h1234);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 0, 1, 1, 0, 23'h012345, 16'h1234);
    add(0, 0, 1, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 0, 1, 1, 0, 23'h012345, 16'h1234);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 0, 1, 1, 0, 23'h012345, 16'h1234);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'hFFFF, 0, 0, 0, 16'hBEEF, 1, 1, 1, 0, 0, 23'h012345, 16'h1234);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    1, 1, 0, 16'hBEEF, 1, 1, 1, 0, 1, 23'h012345, 16'h1234);
    // Read with DTACK coincident with the first WAIT edge, then back-to-back request
    add(0, 0, 0, 1, 1, 23'h000055, 2'b11, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 1, 1, 1, 0, 1, 23'h000055, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 0, 0, 0, 1, 23'h000055, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 0, 0, 0, 1, 23'h000055, 16'h0);
    add(0, 1, 1, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'hBEEF, 0, 0, 0, 0, 1, 23'h000055, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h1357, 0, 0, 0, 16'h1357, 1, 1, 1, 0, 1, 23'h000055, 16'h0);
    add(0, 1, 0, 1, 1, 23'h000066, 2'b01, 16'h0,    16'h0,    1, 1, 0, 16'h1357, 1, 1, 1, 0, 1, 23'h000055, 16'h0);
    add(0, 0, 0, 1, 1, 23'h000066, 2'b01, 16'h0,    16'h0,    0, 0, 0, 16'h1357, 1, 1, 1, 0, 1, 23'h000066, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h1357, 0, 1, 0, 0, 1, 23'h000066, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h1357, 0, 1, 0, 0, 1, 23'h000066, 16'h0);
    add(0, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    0, 0, 0, 16'h1357, 0, 1, 0, 0, 1, 23'h000066, 16'h0);
    // Reset while in WAIT with AS asserted
    add(1, 1, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    1, 0, 0, 16'h0,    1, 1, 1, 0, 1, 23'h0,      16'h0);
    add(0, 0, 0, 0, 1, 23'h0,      2'b00, 16'h0,    16'h0,    1, 0, 0, 16'h0,    1, 1, 1, 0, 1, 23'h0,      16'h0);

    apply_range(0, 17);

    // Timeout: lower-byte read with no DTACK must spend exactly 4 WAIT edges
    rst = 1'b0; dtk = 1'b0; mcf = 1'b0;
    bif.REQ_VALID = 1'b1; bif.REQ_RW = 1'b1; bif.REQ_ADDR = 23'h000007; bif.REQ_BE = 2'b01;
    bif.REQ_WDATA = 16'h0; bif.BUS_DIN = 16'hAAAA;
    tick();
    bif.REQ_VALID = 1'b0;
    mcf = 1'b1;
    tick();
    check1("tmo_assert_strobes", {29'd0, bif.BUS_AS_N, bif.BUS_UDS_N, bif.BUS_LDS_N}, 32'b010);
    tick();
    n = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n = e;
      if (bif.BUS_AS_N === 1'b1) break;
    end
    check1("tmo_wait_edges", 32'(n), 32'd4);
    check1("tmo_term_no_resp", {31'd0, bif.RESP_VALID}, 32'd0);
    tick();
    check1("tmo_resp", {29'd0, bif.RESP_VALID, bif.RESP_ERR, bif.REQ_READY}, 32'b111);
    check1("tmo_rdata_kept", 32'(bif.RESP_RDATA), 32'h0000BEEF);
    mcf = 1'b0;
    tick();
    check1("resp_pulse_single", {30'd0, bif.RESP_VALID, bif.RESP_ERR}, 32'd0);
    mcf = 1'b1;
    tick();
    check1("idle_ignores_mcclk", {30'd0, bif.REQ_READY, bif.BUS_AS_N}, 32'b11);

    apply_range(18, tv.size() - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m68k_bus_fsm.md
M68K_BUS_FSM -- requirements
Module: m68k_bus_fsm

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255, meaning max MCCLK falling edges spent in WAIT before abort.
REQ-002 SHALL have parameter TMO_W, default 8, meaning timeout counter width; WAIT_TIMEOUT < 2^TMO_W.
REQ-003 Ports (name  direction  width  meaning):
- SYSCLK  in  1  sole clock; all logic on negedge SYSCLK, same as the ClockSync strobe domain.
- RESET  in  1  synchronous, active-high reset.
- MCCLK_FALLING  in  1  one-SYSCLK strobe per 68000 clock falling edge.
- DTACK_LATCH  in  1  one-SYSCLK strobe, delay-aligned DTACK assertion.
- REQ_VALID / REQ_READY  in / out  1 / 1  request handshake.
- REQ_RW  in  1  1=read, 0=write.
- REQ_ADDR  in  23  word address A[23:1].
- REQ_BE  in  2  {upper, lower} byte enables, active-high.
- REQ_WDATA  in  16  write data.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_ERR  out  1  timeout flag, valid with RESP_VALID.
- RESP_RDATA  out  16  read data, valid with RESP_VALID.
- BUS_ADDR  out  23  address to bus.
- BUS_RW  out  1  R/W line, 1=read.
- BUS_AS_N, BUS_UDS_N, BUS_LDS_N  out  1 each  active-low strobes.
- BUS_DOUT  out  16  write data to bus.
- BUS_DOE  out  1  data output enable.
- BUS_DIN  in  16  data from bus.

Function
REQ-004 SHALL implement states IDLE, ADDR, ASSERT, WAIT, LATCH, TERM.
REQ-005 IDLE: REQ_READY=1; REQ_VALID&&REQ_READY SHALL capture RW/ADDR/BE/WDATA and enter ADDR next SYSCLK; REQ_READY=0 in all other states.
REQ-006 ADDR: BUS_ADDR and BUS_RW SHALL drive captured values; strobes negated; next MCCLK_FALLING -> ASSERT.
REQ-007 ASSERT: BUS_AS_N=0; read: UDS_N/LDS_N = ~BE; write: BUS_DOE=1, BUS_DOUT=WDATA, DS negated; next MCCLK_FALLING -> WAIT.
REQ-008 WAIT: write SHALL assert DS per ~BE; read keeps DS asserted.
REQ-009 A dtack_seen flag SHALL clear on entering ADDR and set on any DTACK_LATCH while in ASSERT or WAIT.
REQ-010 In WAIT, DTACK_LATCH coincident with MCCLK_FALLING SHALL count as seen on that edge.
REQ-011 In WAIT, on MCCLK_FALLING: dtack_seen -> LATCH; else increment wait counter; counter reaching WAIT_TIMEOUT -> TERM with error set.
REQ-012 LATCH: on MCCLK_FALLING, read SHALL capture BUS_DIN into RESP_RDATA; -> TERM.
REQ-013 TERM: AS_N, UDS_N, LDS_N SHALL be 1 and BUS_DOE=0 from the first SYSCLK in TERM; next MCCLK_FALLING -> IDLE.
REQ-014 On the TERM->IDLE transition, RESP_VALID SHALL pulse exactly one SYSCLK with RESP_ERR; no backpressure.
REQ-015 RESP_RDATA SHALL hold its last value until the next read completes; on timeout it is unchanged.
REQ-016 Wait counter SHALL saturate and never wrap; reset to 0 on entering ADDR.
REQ-017 A REQ_VALID arriving in the RESP_VALID cycle SHALL be accepted, back-to-back.
REQ-018 MCCLK_FALLING in IDLE SHALL have no effect.

Reset
REQ-019 RESET SHALL force next cycle: state IDLE, REQ_READY=1, RESP_VALID=0, RESP_ERR=0, RESP_RDATA=0, BUS_AS_N=UDS_N=LDS_N=1, BUS_RW=1, BUS_DOE=0, BUS_ADDR=0, BUS_DOUT=0, counter 0, dtack_seen 0.
REQ-020 RESET mid-cycle SHALL abort without RESP_VALID; strobes negate within one SYSCLK.

Structure
REQ-021 State encoding, WAIT_TIMEOUT default and strobe idle levels SHALL live in shared package m68k_bus_pkg.
REQ-022 Wait counter with saturation SHALL be sub-module bus_wait_timer; everything else is one module.

Verification
REQ-023 Read, BE=2'b11, ADDR=23'h000400, DTACK_LATCH in 2nd WAIT, BUS_DIN=16'hBEEF -> UDS_N/LDS_N low from ASSERT; RESP_VALID once, RESP_RDATA=16'hBEEF, RESP_ERR=0.
REQ-024 Write, BE=2'b10, WDATA=16'h1234 -> BUS_DOE=1 from ASSERT; UDS_N low only from WAIT; LDS_N stays 1; DOE=0 in TERM.
REQ-025 No DTACK, WAIT_TIMEOUT=4 -> exactly 4 WAIT falling edges, then TERM; RESP_ERR=1; RESP_RDATA unchanged.
REQ-026 DTACK_LATCH in the same SYSCLK as MCCLK_FALLING in WAIT -> LATCH taken on that edge, no extra wait.
REQ-027 RESET asserted in WAIT with AS_N=0 -> AS_N=1 and IDLE next SYSCLK; no RESP_VALID.
REQ-028 Second REQ_VALID held during RESP_VALID -> accepted that cycle; ADDR state next SYSCLK.
